// File: rtl/p_dot_mac_if.sv
// p_dot_mac bus: control, shared RAM read port and result.
// master drives requests and RAM data, slave is the MAC engine.
interface p_dot_mac_if #(
  parameter int D_WIDTH   = 4,
  parameter int A_WIDTH   = 4,
  parameter int ACC_WIDTH = 2*D_WIDTH+A_WIDTH
);
  logic                        start;
  logic        [A_WIDTH-1:0]   len;
  logic                        relu_en;
  logic        [A_WIDTH-1:0]   r_addr;
  logic signed [D_WIDTH-1:0]   w_data;
  logic signed [D_WIDTH-1:0]   x_data;
  logic signed [ACC_WIDTH-1:0] acc_out;
  logic                        busy;
  logic                        done;

  modport master (
    output start, len, relu_en,
    output w_data, x_data,
    input  r_addr, acc_out, busy, done
  );

  modport slave (
    input  start, len, relu_en,
    input  w_data, x_data,
    output r_addr, acc_out, busy, done
  );
endinterface

// File: rtl/p_dot_mac.sv
// p_dot_mac: sequential dot product of weight and activation
// vectors read from two one-cycle-latency RAMs, optional ReLU.
module p_dot_mac #(
  parameter int D_WIDTH   = 4,
  parameter int A_WIDTH   = 4,
  parameter int ACC_WIDTH = 2*D_WIDTH+A_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  p_dot_mac_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                      r_state;
  logic        [A_WIDTH-1:0]   r_addr;
  logic        [A_WIDTH-1:0]   r_len;
  logic                        r_relu;
  logic                        r_valid_d;
  logic                        r_busy;
  logic                        r_done;
  logic signed [ACC_WIDTH-1:0] r_acc;

  logic signed [2*D_WIDTH-1:0] w_w_ext;
  logic signed [2*D_WIDTH-1:0] w_x_ext;
  logic signed [2*D_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0] w_term;

  // operands widened first so the product is exact at 2*D_WIDTH
  assign w_w_ext = {{D_WIDTH{bus.w_data[D_WIDTH-1]}}, bus.w_data};
  assign w_x_ext = {{D_WIDTH{bus.x_data[D_WIDTH-1]}}, bus.x_data};
  assign w_prod  = w_w_ext * w_x_ext;
  assign w_term  = ACC_WIDTH'(w_prod);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_relu    <= 1'b0;
      r_valid_d <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_acc     <= '0;
    end else begin
      r_valid_d <= (r_state == S_FETCH);
      r_done    <= 1'b0;
      if (r_valid_d)
        r_acc <= r_acc + w_term;
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_FETCH;
            r_addr  <= '0;
            r_acc   <= '0;
            r_len   <= bus.len;
            r_relu  <= bus.relu_en;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          // last address leaves FETCH, so the counter never wraps
          if (r_addr == r_len) begin
            r_state <= S_DRAIN;
            r_addr  <= '0;
          end else begin
            r_addr <= r_addr + A_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.r_addr  = r_addr;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.acc_out = (r_relu && r_acc[ACC_WIDTH-1]) ? '0 : r_acc;

endmodule

// File: tb/tb_p_dot_mac.sv
// tb_p_dot_mac: directed vectors against hand-computed results,
// with one-cycle-latency weight/activation RAM models.
module tb_p_dot_mac;

  localparam int DW = 4;
  localparam int AW = 4;
  localparam int CW = 2*DW+AW;

  logic clk;
  logic rst;

  p_dot_mac_if #(.D_WIDTH(DW), .A_WIDTH(AW), .ACC_WIDTH(CW)) bus ();

  p_dot_mac #(.D_WIDTH(DW), .A_WIDTH(AW), .ACC_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic signed [DW-1:0] wmem [16];
  logic signed [DW-1:0] xmem [16];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.w_data <= wmem[bus.r_addr];
    bus.x_data <= xmem[bus.r_addr];
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int acc_val();
    return int'($signed(bus.acc_out));
  endfunction

  task automatic load(input int w0, input int x0, input int n);
    for (int i = 0; i < 16; i++) begin
      wmem[i] = DW'(w0);
      xmem[i] = DW'(x0);
    end
    n = n;
  endtask

  // lat: edges from E0 to the first done; ok: address/busy sequence
  task automatic run_op(input int l, input bit relu, input int restart_k,
                        output int lat, output int ndone, output bit ok);
    lat = -1;
    ndone = 0;
    ok = 1'b1;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.len     = AW'(l);
    bus.relu_en = relu;
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.len     = AW'(l + 5);
    bus.relu_en = ~relu;
    for (int k = 0; k < 60; k++) begin
      if (k <= l && (int'(bus.r_addr) != k || !bus.busy)) ok = 1'b0;
      if (k == l + 1 && (bus.r_addr != '0 || !bus.busy)) ok = 1'b0;
      bus.start = (k == restart_k);
      @(posedge clk);
      #1;
      if (bus.done) begin
        ndone++;
        if (bus.busy) ok = 1'b0;
        if (lat < 0) lat = k + 1;
      end
      if (lat > 0 && k > lat + 3) break;
    end
    bus.start = 1'b0;
  endtask

  int lat;
  int nd;
  bit ok;
  int dn;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.len = '0;
    bus.relu_en = 1'b0;
    load(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_addr", int'(bus.r_addr), 0);
    check("rst_acc", acc_val(), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    rst = 1'b0;

    load(0, 1, 0);
    for (int i = 0; i < 4; i++) wmem[i] = DW'(i + 1);
    run_op(3, 1'b0, -1, lat, nd, ok);
    check("sum10_lat", lat, 5);
    check("sum10_seq", int'(ok), 1);
    check("sum10_acc", acc_val(), 10);
    check("sum10_ndone", nd, 1);

    load(0, 0, 0);
    wmem[0] = -4'sd8; wmem[1] = -4'sd8;
    xmem[0] = -4'sd8; xmem[1] = 4'sd7;
    run_op(1, 1'b0, -1, lat, nd, ok);
    check("ext_lat", lat, 3);
    check("ext_acc", acc_val(), 8);

    load(0, 0, 0);
    wmem[0] = -4'sd1; wmem[1] = -4'sd1;
    xmem[0] = 4'sd3;  xmem[1] = 4'sd3;
    run_op(1, 1'b1, -1, lat, nd, ok);
    check("relu_acc", acc_val(), 0);
    run_op(1, 1'b0, -1, lat, nd, ok);
    check("raw_acc", acc_val(), -6);

    load(0, 0, 0);
    wmem[0] = -4'sd8; xmem[0] = -4'sd8;
    run_op(0, 1'b0, -1, lat, nd, ok);
    check("len0_lat", lat, 2);
    check("len0_acc", acc_val(), 64);
    check("len0_seq", int'(ok), 1);

    load(-8, -8, 0);
    run_op(15, 1'b0, -1, lat, nd, ok);
    check("full_lat", lat, 17);
    check("full_seq", int'(ok), 1);
    check("full_acc", acc_val(), 1024);
    repeat (3) @(posedge clk);
    #1;
    check("full_hold", acc_val(), 1024);

    load(0, 1, 0);
    for (int i = 0; i < 4; i++) wmem[i] = DW'(i + 1);
    run_op(3, 1'b0, 1, lat, nd, ok);
    check("restart_ndone", nd, 1);
    check("restart_acc", acc_val(), 10);
    check("restart_lat", lat, 5);

    @(negedge clk);
    bus.start = 1'b1;
    bus.len = 4'd3;
    bus.relu_en = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_acc", acc_val(), 0);
    check("abort_addr", int'(bus.r_addr), 0);
    dn = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) dn++;
    end
    check("abort_nodone", dn, 0);

    run_op(3, 1'b0, -1, lat, nd, ok);
    check("after_lat", lat, 5);
    check("after_acc", acc_val(), 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
